// File: rtl/mat_vec_mul_ctrl_if.sv
// Stream bundle for mat_vec_mul_ctrl: frame words in, result words out.
// The slave side is the controller; the master side is upstream/downstream.
interface mat_vec_mul_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mat_vec_mul_ctrl.sv
// Sequencer for the mat_vec_mul datapath: loads a matrix+vector frame, waits the
// datapath latency, captures the result and drains it as a stream.
module mat_vec_mul_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAT_ROW     = 4,
  parameter int MAT_COL     = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          abort,
  mat_vec_mul_ctrl_if.slave                             bus,
  output logic [MAT_ROW-1:0][MAT_COL-1:0][DATA_WIDTH-1:0] mat_o,
  output logic [MAT_COL-1:0][DATA_WIDTH-1:0]              vec_o,
  input  logic [MAT_ROW-1:0][DATA_WIDTH-1:0]              res_i,
  output logic                                          busy
);

  localparam int MAT_N  = MAT_ROW * MAT_COL;
  localparam int N      = MAT_N + MAT_COL;
  localparam int IN_W   = (N > 1) ? $clog2(N) : 1;
  localparam int WAIT_W = $clog2(MUL_LATENCY + 1);
  localparam int OUT_W  = (MAT_ROW > 1) ? $clog2(MAT_ROW) : 1;

  localparam logic [IN_W-1:0]   IN_LAST   = IN_W'(N - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MUL_LATENCY - 1);
  localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(MAT_ROW - 1);

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  logic [1:0]                            state;
  logic [IN_W-1:0]                       in_cnt;
  logic [WAIT_W-1:0]                     wait_cnt;
  logic [OUT_W-1:0]                      out_idx;
  logic [MAT_ROW-1:0][DATA_WIDTH-1:0]    res_buf;
  logic                                  in_hs;

  assign in_hs = bus.in_valid && (state == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      in_cnt   <= '0;
      wait_cnt <= '0;
      out_idx  <= '0;
    end else if (abort) begin
      state    <= LOAD;
      in_cnt   <= '0;
      wait_cnt <= '0;
      out_idx  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            if (in_cnt == IN_LAST) begin
              in_cnt <= '0;
              state  <= WAIT;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        CAPTURE: state <= DRAIN;
        DRAIN: begin
          if (bus.out_ready) begin
            if (out_idx == OUT_LAST) begin
              out_idx <= '0;
              state   <= LOAD;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Operand slots are written only on accepted words, so they stay frozen through WAIT/CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_o <= '0;
      vec_o <= '0;
    end else if (in_hs && !abort) begin
      for (int r = 0; r < MAT_ROW; r++) begin
        for (int c = 0; c < MAT_COL; c++) begin
          if (in_cnt == IN_W'(r * MAT_COL + c)) mat_o[r][c] <= bus.in_data;
        end
      end
      for (int c = 0; c < MAT_COL; c++) begin
        if (in_cnt == IN_W'(MAT_N + c)) vec_o[c] <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_buf <= '0;
    end else if ((state == CAPTURE) && !abort) begin
      res_buf <= res_i;
    end
  end

  // Handshake outputs come from registered state only; in_ready is also masked during reset
  assign bus.in_ready  = rst_n && (state == LOAD);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_last  = (state == DRAIN) && (out_idx == OUT_LAST);
  assign bus.out_data  = (state == DRAIN) ? res_buf[out_idx] : '0;
  assign busy          = (state != LOAD);

endmodule

// File: doc/mat_vec_mul_ctrl.md
# mat_vec_mul_ctrl

Sequencing controller for the `mat_vec_mul` datapath. It accepts a frame from a valid/ready input stream: the matrix in row-major order, followed by the vector. It holds the assembled operands stable on the datapath inputs for a fixed number of cycles, then captures the result vector. It then drains the result vector element by element on a valid/ready output stream, with a last marker on the final element.

## Interface
- `DATA_WIDTH`, 32, width of every element and result word
- `MAT_ROW`, 4, matrix rows (result length)
- `MAT_COL`, 4, matrix columns (vector length)
- `MUL_LATENCY`, 2, cycles from operands stable to `res_i` valid (≥1)

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `abort` in 1: synchronous frame discard
- `in_valid` in 1: input word valid
- `in_ready` out 1: controller accepts input word
- `in_data` in DATA_WIDTH: matrix or vector element
- `mat_o` out DATA_WIDTH × [MAT_ROW][MAT_COL]: operand matrix to the datapath `mat`
- `vec_o` out DATA_WIDTH × [MAT_COL]: operand vector to the datapath `vec`
- `res_i` in DATA_WIDTH × [MAT_ROW]: datapath `res`
- `out_valid` out 1: result word valid
- `out_ready` in 1: downstream accepts result word
- `out_data` out DATA_WIDTH: result element
- `out_last` out 1: high with the element at index MAT_ROW-1
- `busy` out 1: high in WAIT, CAPTURE or DRAIN

## Operation
- Frame definition:
  - N = MAT_ROW·MAT_COL + MAT_COL words.
  - Word k < MAT_ROW·MAT_COL goes to `mat_o[k/MAT_COL][k%MAT_COL]`.
  - Remaining words go to `vec_o[k-MAT_ROW·MAT_COL]`.
- States: LOAD, WAIT, CAPTURE, DRAIN.
- LOAD:
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready`) writes `in_data` to the slot at index `in_cnt` and increments `in_cnt`.
  - The handshake at `in_cnt`=N-1 moves the FSM to WAIT and clears `in_cnt`.
- WAIT:
  - `in_ready`=0; operand registers are frozen.
  - `wait_cnt` counts 0..MUL_LATENCY-1; at MUL_LATENCY-1 the FSM moves to CAPTURE.
- CAPTURE: for one cycle, `res_i` is latched into `res_buf` at the end of the cycle; next state is DRAIN.
- DRAIN:
  - `out_valid`=1, `out_data`=`res_buf[out_idx]`, `out_last`=(`out_idx`==MAT_ROW-1).
  - Each output handshake increments `out_idx`.
  - The handshake with `out_last` returns the FSM to LOAD and clears `out_idx`.
- Operand registers keep their last frame until overwritten; slots not yet rewritten in LOAD keep their old values.
- Counter widths:
  - `in_cnt`: $clog2(N).
  - `wait_cnt`: $clog2(MUL_LATENCY+1).
  - `out_idx`: $clog2(MAT_ROW), minimum 1 bit.
  - No counter wraps except through the explicit clear.
- No arithmetic is done in this block. Result width equals DATA_WIDTH exactly as the datapath delivers it; no saturation.
- `abort`:
  - In any state, on the next edge: FSM to LOAD, all counters cleared, `res_buf` unchanged, operand registers unchanged.
  - `abort` has priority over a same-cycle input or output handshake; that word is dropped.
- Reset (`rst_n`=0), asynchronous and immediate:
  - FSM=LOAD; all counters 0; `mat_o`, `vec_o`, `res_buf` all 0.
  - Outputs: `in_ready`=1 after release, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0.
  - `in_ready` is 0 while `rst_n` is low.
  - Reset mid-frame discards the frame.

## Timing
- `in_ready`, `out_valid`, `out_last`, `busy` are decoded from registered state only; no combinational path from `in_valid` or `out_ready`.
- Let cycle t be the last input handshake. Then:
  - WAIT occupies cycles t+1..t+MUL_LATENCY.
  - CAPTURE occupies t+MUL_LATENCY+1.
  - The first `out_valid` is at t+MUL_LATENCY+2.
- Output drain takes exactly MAT_ROW cycles when `out_ready` is held at 1.
- Back-pressure: while `out_valid`&!`out_ready`, `out_data` and `out_last` hold stable.
- `in_ready` rises on the cycle after the `out_last` handshake.
- No overlap of load and drain; frame throughput = N + MUL_LATENCY + 1 + MAT_ROW cycles minimum.
- `mat_o`/`vec_o` change only on LOAD handshakes, so they are stable for the full WAIT+CAPTURE window.

## Test plan
- Identity matrix, vec={3,5,7,9}, `out_ready`=1 → `out_data` 3,5,7,9 on consecutive cycles, `out_last` on 9, `in_ready` back the next cycle.
- All elements 255 (with a golden model of the datapath) → each result 4·255·255=260100; first `out_valid` exactly MUL_LATENCY+2 cycles after the 20th input handshake.
- `out_ready` toggles 1,0,0,1,… during drain → no word lost or duplicated; `out_data` is stable on stalled cycles; exactly 4 handshakes.
- `in_valid` gapped randomly (10 random frames, 0..255 values) → results match the reference multiply, and `mat_o`/`vec_o` stay constant throughout WAIT.
- `abort` after 7 input words, then a full new frame → the result reflects only the new frame; no `out_valid` before it completes.
- `rst_n` low during DRAIN at `out_idx`=2 → `out_valid`=0 and `busy`=0 immediately; after release `in_ready`=1, `mat_o`=0, and the next frame produces a correct result.
